// File: rtl/alu_op_pkg.sv
// Package: alu_op_pkg
// Shared constants for the ALU operation bus: 4-bit ALU op codes, instruction
// opcode/funct field values, and the issuer FSM state type. Also used by the
// ALU logic/arith units.
package alu_op_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1010;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Module: alu_op_decode
// Combinational map from instruction opcode/funct fields to the 4-bit ALU op.
// Unrecognised encodings produce OP_AND so the default build always has a
// legal op to execute.
// Ports:
//   opcode  in   6  instruction opcode field
//   funct   in   6  R-type funct field (ignored for I-type)
//   op      out  4  ALU op code
//   illegal out  1  encoding not recognised (only with ALU_OP_ILLEGAL_EN)
// Build option: ALU_OP_ILLEGAL_EN adds the illegal output.
module alu_op_decode
  import alu_op_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] op
`ifdef ALU_OP_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  logic       hit;
  logic [3:0] op_raw;

  always_comb begin
    hit    = 1'b1;
    op_raw = OP_AND;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD:  op_raw = OP_ADD;
          FN_SUB:  op_raw = OP_SUB;
          FN_AND:  op_raw = OP_AND;
          FN_OR:   op_raw = OP_OR;
          FN_XOR:  op_raw = OP_XOR;
          FN_NOR:  op_raw = OP_NOR;
          FN_SLT:  op_raw = OP_SLT;
          default: hit    = 1'b0;
        endcase
      end
      OPC_ADDI: op_raw = OP_ADD;
      OPC_ANDI: op_raw = OP_AND;
      OPC_ORI:  op_raw = OP_OR;
      OPC_XORI: op_raw = OP_XOR;
      default:  hit    = 1'b0;
    endcase
  end

  assign op = hit ? op_raw : OP_AND;

`ifdef ALU_OP_ILLEGAL_EN
  assign illegal = ~hit;
`endif

endmodule

// File: rtl/alu_op_issuer.sv
// Module: alu_op_issuer
// Control-side producer for the ALU operation bus. Accepts decoded instruction
// fields plus operands on a valid/ready handshake, registers operands and op
// to the ALU, waits ALU_LAT cycles, then presents the captured result on a
// valid/ready output. One request in flight at a time.
//
//   state | meaning
//   IDLE  | ready for a request (in_ready=1)
//   EXEC  | ALU inputs held, down-counter running to terminal count
//   RESP  | result presented (out_valid=1) until out_ready
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            request handshake
//   opcode, funct, src_a, src_b  request fields
//   alu_a, alu_b, alu_op         registered ALU inputs
//   alu_result                   ALU output
//   out_valid/out_ready          response handshake
//   out_result                   captured result
//   out_illegal                  illegal-decode flag (only with ALU_OP_ILLEGAL_EN)
// Build option: ALU_OP_ILLEGAL_EN makes illegal encodings bypass the ALU and
// respond with out_result=0, out_illegal=1.
module alu_op_issuer
  import alu_op_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
`ifdef ALU_OP_ILLEGAL_EN
  ,
  output logic              out_illegal
`endif
);

  // Counter only has to hold ALU_LAT-1.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_op;
  logic             accept, load_alu, capture, done;

`ifdef ALU_OP_ILLEGAL_EN
  logic dec_ill;
  logic skip;

  alu_op_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .op      (dec_op),
    .illegal (dec_ill)
  );
`else
  alu_op_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .op     (dec_op)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_alu  = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
`ifdef ALU_OP_ILLEGAL_EN
    skip      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          load_alu  = 1'b1;
          state_nxt = ST_EXEC;
`ifdef ALU_OP_ILLEGAL_EN
          if (dec_ill) begin
            // Illegal requests never reach the ALU; its inputs keep old values.
            skip      = 1'b1;
            load_alu  = 1'b0;
            state_nxt = ST_RESP;
          end
`endif
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(ALU_LAT - 1);
    end else if (state == ST_EXEC && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_ADD;
    end else if (load_alu) begin
      alu_a  <= src_a;
      alu_b  <= src_b;
      alu_op <= dec_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
    end else if (capture) begin
      out_result <= alu_result;
`ifdef ALU_OP_ILLEGAL_EN
    end else if (skip) begin
      out_result <= '0;
`endif
    end
  end

`ifdef ALU_OP_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_illegal <= 1'b0;
    else if (skip)    out_illegal <= 1'b1;
    else if (capture) out_illegal <= 1'b0;
    else if (done)    out_illegal <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench: tb_alu_op_issuer
// Directed tests for alu_op_issuer with ALU_LAT=3 and a simple behavioural
// ALU on the alu_* bus. Inputs are driven and outputs sampled on the falling
// clock edge. Build option ALU_OP_ILLEGAL_EN selects the illegal-decode checks.
module tb_alu_op_issuer;

  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [5:0]    opcode, funct;
  logic [DW-1:0] src_a, src_b;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
`ifdef ALU_OP_ILLEGAL_EN
  logic          out_illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct      (funct),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef ALU_OP_ILLEGAL_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  // Behavioural ALU seen by the issuer.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a & alu_b;
      4'b0101: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a ^ alu_b;
      4'b0111: alu_result = ~(alu_a | alu_b);
      4'b1010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
  end

  // Present a request for one cycle; returns whether it was ready when driven.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      output logic rdy);
    opcode   = opc;
    funct    = fn;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    rdy      = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Number of falling edges from request drive until out_valid (bounded).
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (alu_a !== 32'h0)      begin errors++; $display("FAIL reset_alu_a got %h exp 0", alu_a); end
    checks++; if (alu_b !== 32'h0)      begin errors++; $display("FAIL reset_alu_b got %h exp 0", alu_b); end
    checks++; if (alu_op !== 4'b0000)   begin errors++; $display("FAIL reset_alu_op got %b exp 0000", alu_op); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and();
    logic rdy; int cyc;
    send(6'h00, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL and_in_ready got %b exp 1", rdy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL and_busy got %b exp 0", in_ready); end
    wait_resp(cyc);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL and_latency got %0d exp %0d", cyc, LAT + 1); end
    checks++; if (alu_op !== 4'b0100) begin errors++; $display("FAIL and_alu_op got %b exp 0100", alu_op); end
    checks++; if (alu_a !== 32'hF0F0_F0F0 || alu_b !== 32'hFF00_FF00)
      begin errors++; $display("FAIL and_operands got %h %h exp f0f0f0f0 ff00ff00", alu_a, alu_b); end
    checks++; if (out_result !== 32'hF000_F000) begin errors++; $display("FAIL and_result got %h exp f000f000", out_result); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL and_handshake got valid=%b ready=%b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_ops();
    logic rdy; int cyc;
    // opcode, funct, a, b, expected op, expected result
    logic [5:0]    v_opc [5] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h00};
    logic [5:0]    v_fn  [5] = '{6'h27, 6'h22, 6'h2A, 6'h00, 6'h25};
    logic [DW-1:0] v_a   [5] = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0F00_0000};
    logic [DW-1:0] v_b   [5] = '{32'h0, 32'h7, 32'h1, 32'h2, 32'h0000_00F0};
    logic [3:0]    v_op  [5] = '{4'b0111, 4'b0001, 4'b1010, 4'b0000, 4'b0101};
    logic [DW-1:0] v_res [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h1, 32'h0F00_00F0};
    for (int i = 0; i < 5; i++) begin
      send(v_opc[i], v_fn[i], v_a[i], v_b[i], rdy);
      wait_resp(cyc);
      checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL op%0d_latency got %0d exp %0d", i, cyc, LAT + 1); end
      checks++; if (alu_op !== v_op[i]) begin errors++; $display("FAIL op%0d_alu_op got %b exp %b", i, alu_op, v_op[i]); end
      checks++; if (out_result !== v_res[i]) begin errors++; $display("FAIL op%0d_result got %h exp %h", i, out_result, v_res[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic rdy; int cyc;
    send(6'h00, 6'h26, 32'h1234_5678, 32'hFFFF_0000, rdy);
    wait_resp(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hEDCB_5678 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b res=%h ready=%b exp 1 edcb5678 0", i, out_valid, out_result, in_ready);
      end
      @(negedge clk);
    end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic rdy; int cyc;
    send(6'h0D, 6'h00, 32'h0000_1200, 32'h0000_00FF, rdy);
    wait_resp(cyc);
    checks++; if (alu_op !== 4'b0101) begin errors++; $display("FAIL b2b_ori_op got %b exp 0101", alu_op); end
    checks++; if (out_result !== 32'h0000_12FF) begin errors++; $display("FAIL b2b_first got %h exp 000012ff", out_result); end
    consume();
    send(6'h0C, 6'h00, 32'hABCD_1234, 32'h0000_FFFF, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", rdy); end
    wait_resp(cyc);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", cyc, LAT + 1); end
    checks++; if (out_result !== 32'h0000_1234) begin errors++; $display("FAIL b2b_second got %h exp 00001234", out_result); end
    consume();
  endtask

  task automatic test_reset_mid_exec();
    logic rdy; int seen;
    send(6'h00, 6'h20, 32'h1, 32'h2, rdy);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rst_exec_state got ready=%b valid=%b exp 1 0", in_ready, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_exec_no_result got %0d valid cycles exp 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_illegal();
    logic rdy; int cyc;
    // Known previous ALU op (XOR) before the illegal request.
    send(6'h0E, 6'h00, 32'h0000_00F0, 32'h0000_00FF, rdy);
    wait_resp(cyc);
    consume();
    send(6'h3F, 6'h00, 32'hFFFF_0000, 32'h00FF_FF00, rdy);
    wait_resp(cyc);
`ifdef ALU_OP_ILLEGAL_EN
    checks++; if (cyc !== 1) begin errors++; $display("FAIL ill_latency got %0d exp 1", cyc); end
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", out_illegal); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL ill_result got %h exp 0", out_result); end
    checks++; if (alu_op !== 4'b0110 || alu_a !== 32'h0000_00F0)
      begin errors++; $display("FAIL ill_alu_hold got op=%b a=%h exp 0110 000000f0", alu_op, alu_a); end
    consume();
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got %b exp 0", out_illegal); end
`else
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL ill_latency got %0d exp %0d", cyc, LAT + 1); end
    checks++; if (alu_op !== 4'b0100) begin errors++; $display("FAIL ill_alu_op got %b exp 0100", alu_op); end
    checks++; if (out_result !== 32'h00FF_0000) begin errors++; $display("FAIL ill_result got %h exp 00ff0000", out_result); end
    consume();
`endif
  endtask

  initial begin
    test_reset();
    test_and();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
